// File: rtl/fifo_word_packer.sv
// Drains bytes from an 8-bit FIFO, packs PACK of them little-endian into one word
// and offers it on a valid/ready port; partial words leave on flush or idle timeout.
module fifo_word_packer #(
  parameter  int DATA_W    = 8,
  parameter  int PACK      = 4,
  parameter  int FLUSH_CYC = 16,
  localparam int OUT_W     = DATA_W * PACK,
  localparam int CW        = $clog2(PACK + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              rd,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic [CW-1:0]     m_bytes
);

  localparam int TW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_OUT = 2'd2} state_e;

  state_e                     state_q, state_d;
  logic [PACK-1:0][DATA_W-1:0] lanes_q, lanes_d, out_lanes;
  logic [CW-1:0]              cnt_q, cnt_d, iss_q, iss_d, bytes_q, bytes_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic                       pend_q, fpend_q, fpend_d;
  logic                       acc, tmo, flush_go;

  assign rd      = rst & (state_q != S_OUT) & ~fifo_empty & (iss_q < CW'(PACK)) & ~fpend_q;
  assign acc     = rd & ~fifo_empty;
  assign m_valid = (state_q == S_OUT);
  assign m_bytes = bytes_q;
  assign m_data  = out_lanes;

  // The last byte of a full word lands in the first OUT cycle; forward it so the
  // word is presented one cycle earlier and a full word costs PACK+1 cycles.
  always_comb begin
    out_lanes = lanes_q;
    if (state_q == S_OUT && pend_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) out_lanes[i] = fifo_dout;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lanes_d  = lanes_q;
    cnt_d    = cnt_q;
    iss_d    = iss_q;
    bytes_d  = bytes_q;
    fpend_d  = fpend_q;
    timer_d  = '0;
    if (state_q == S_FILL && !acc && !pend_q)
      timer_d = (timer_q < TW'(FLUSH_CYC)) ? timer_q + 1'b1 : timer_q;
    tmo      = (FLUSH_CYC != 0) && (timer_d == TW'(FLUSH_CYC));
    flush_go = (state_q == S_FILL) && (cnt_q != '0) && !pend_q && (iss_q == cnt_q) &&
               !acc && (flush || fpend_q || tmo);

    if (pend_q) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) lanes_d[i] = fifo_dout;
      end
      cnt_d = cnt_q + 1'b1;
    end
    if (acc) iss_d = iss_q + 1'b1;
    // a flush with nothing captured or in flight is dropped on the spot
    if (flush && state_q != S_OUT) fpend_d = (cnt_q != '0) || pend_q;

    case (state_q)
      S_IDLE: if (acc) state_d = S_FILL;
      S_FILL: begin
        if (acc && iss_q == CW'(PACK - 1)) begin
          state_d = S_OUT;
          bytes_d = CW'(PACK);
        end else if (flush_go) begin
          state_d = S_OUT;
          bytes_d = cnt_q;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          state_d = S_IDLE;
          lanes_d = '0;
          cnt_d   = '0;
          iss_d   = '0;
          bytes_d = '0;
          fpend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != S_FILL) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lanes_q <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      bytes_q <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      bytes_q <= bytes_d;
      timer_q <= timer_d;
      pend_q  <= acc;
      fpend_q <= fpend_d;
    end
  end

endmodule
